// File: rtl/conv2d_pkg.sv
// Shared definitions for the conv2d frame source/sink family.
//   src_state_e   : frame source FSM states
//   CONV_*        : default engine geometry
//   flush_default : padding beats needed to drain a DEPTH-wide window
//                   (two extra beats cover the 3x3 window's pipeline tail)
package conv2d_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } src_state_e;

    localparam int CONV_WIDTH  = 8;
    localparam int CONV_DEPTH  = 16;
    localparam int CONV_HEIGHT = 16;

    function automatic int flush_default(input int depth);
        return depth + 2;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row raster position counter for a DEPTH_P x HEIGHT_P frame.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : return to (0,0); has priority over en_i
//   en_i         : advance one pixel in raster order (wraps after last)
//   sof_o        : current position is (0,0)
//   eol_o        : current position is the last column
//   last_o       : current position is the last pixel of the frame
module raster_counter #(
    parameter int DEPTH_P  = 16,
    parameter int HEIGHT_P = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic sof_o,
    output logic eol_o,
    output logic last_o
);
    localparam int CW = (DEPTH_P  > 1) ? $clog2(DEPTH_P)  : 1;
    localparam int RW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    assign sof_o  = (col_q == '0) && (row_q == '0);
    assign eol_o  = (col_q == CW'(DEPTH_P - 1));
    assign last_o = eol_o && (row_q == RW'(HEIGHT_P - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (en_i) begin
            if (eol_o) begin
                col_d = '0;
                row_d = last_o ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/conv2d_frame_src.sv
// Frame source for the 3x3 convolution engines. Forwards one raster frame
// from an upstream valid/ready source, tags sof/eol, then appends FLUSH_P
// padding beats so the engine's line buffers drain.
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   start_i                 : begin a frame (honoured only in IDLE)
//   busy_o, done_o          : frame in progress / one-cycle completion pulse
//   valid_i, ready_o, data_i: upstream pixel interface
//   valid_o, ready_i, data_o: downstream pixel interface (single register)
//   sof_o, eol_o, pad_o     : sideband qualifying the downstream beat
// Build option: CONV2D_SRC_REPLICATE_EN makes pad beats repeat the frame's
// last real pixel instead of PAD_P.
module conv2d_frame_src
    import conv2d_pkg::*;
#(
    parameter int                 WIDTH_P  = CONV_WIDTH,
    parameter int                 DEPTH_P  = CONV_DEPTH,
    parameter int                 HEIGHT_P = CONV_HEIGHT,
    parameter int                 FLUSH_P  = flush_default(DEPTH_P),
    parameter logic [WIDTH_P-1:0] PAD_P    = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH_P-1:0] data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH_P-1:0] data_o,
    output logic               sof_o,
    output logic               eol_o,
    output logic               pad_o
);
    localparam int PW = $clog2(FLUSH_P + 1);

    src_state_e         state_q, state_d;
    logic [PW-1:0]      padcnt_q;
    logic               valid_q, sof_q, eol_q, pad_q;
    logic [WIDTH_P-1:0] data_q;
    logic [WIDTH_P-1:0] pad_val;

    logic free, up_hs, pad_load, load, start_go;
    logic pix_sof, pix_eol, pix_last;

    assign start_go = (state_q == IDLE) && start_i;

    raster_counter #(
        .DEPTH_P (DEPTH_P),
        .HEIGHT_P(HEIGHT_P)
    ) u_raster (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (start_go),
        .en_i  (up_hs),
        .sof_o (pix_sof),
        .eol_o (pix_eol),
        .last_o(pix_last)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start_i) state_d = STREAM;
            STREAM: if (up_hs && pix_last) state_d = FLUSH;
            // Loads stop once padcnt reaches FLUSH_P, so a pad beat leaving
            // the register at that count is the final one.
            FLUSH:  if (valid_q && ready_i && pad_q && (padcnt_q == PW'(FLUSH_P)))
                        state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        free     = !valid_q || ready_i;
        ready_o  = (state_q == STREAM) && free;
        up_hs    = valid_i && ready_o;
        pad_load = (state_q == FLUSH) && free && (padcnt_q != PW'(FLUSH_P));
        load     = up_hs || pad_load;
        busy_o   = (state_q == STREAM) || (state_q == FLUSH);
        done_o   = (state_q == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         padcnt_q <= '0;
        else if (start_go) padcnt_q <= '0;
        else if (pad_load) padcnt_q <= padcnt_q + 1'b1;
    end

    // Single-stage output register; flags only move on a load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            pad_q   <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= up_hs ? data_i : pad_val;
            sof_q   <= up_hs && pix_sof;
            eol_q   <= up_hs && pix_eol;
            pad_q   <= pad_load;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

`ifdef CONV2D_SRC_REPLICATE_EN
    logic [WIDTH_P-1:0] last_pix_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                  last_pix_q <= '0;
        else if (up_hs && pix_last) last_pix_q <= data_i;
    end

    assign pad_val = last_pix_q;
`else
    assign pad_val = PAD_P;
`endif

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign sof_o   = sof_q;
    assign eol_o   = eol_q;
    assign pad_o   = pad_q;

endmodule

// File: doc/conv2d_frame_src.md
Name: conv2d_frame_src

Overview:
Frame transmitter that feeds the 3x3 convolution engines (box/Sobel) over their valid/ready pixel interface. It accepts raw pixels from an upstream source, such as a UART or memory reader, and forwards exactly one frame in raster order with start-of-frame and end-of-line sideband. After the last real pixel it injects flush padding so the engine's line buffers drain the final window rows. It sits between the pixel source and the conv2d_* block, mirroring that block's WIDTH_P/DEPTH_P geometry.

Parameters:
WIDTH_P, 8, pixel bit width.
DEPTH_P, 16, pixels per line; must match the downstream engine's DEPTH_P.
HEIGHT_P, 16, lines per frame, >= 3.
FLUSH_P, DEPTH_P+2, number of padding beats appended after the last real pixel, >= 1.
PAD_P, 0, padding pixel value, WIDTH_P bits.

Ports:
clk_i  in  1  clock; all logic on the rising edge.
rst_i  in  1  reset, asynchronous, active-high.
start_i  in  1  begin one frame; sampled only in IDLE.
busy_o  out  1  high in STREAM or FLUSH.
done_o  out  1  one-cycle pulse at frame completion.
valid_i  in  1  upstream pixel valid.
ready_o  out  1  upstream ready.
data_i  in  WIDTH_P  upstream pixel.
valid_o  out  1  downstream valid, to the engine's valid_i.
ready_i  in  1  downstream ready, from the engine's ready_o.
data_o  out  WIDTH_P  downstream pixel.
sof_o  out  1  qualifies the beat for pixel (0,0).
eol_o  out  1  qualifies the beat for the last column of each real line.
pad_o  out  1  qualifies a flush/padding beat.

Behaviour:
- Reset (async assert, sync-released logic): state IDLE; col, row, and pad counters 0; valid_o, busy_o, done_o, sof_o, eol_o, pad_o all 0; data_o 0.
- Output register: a single stage with no skid. The register is free when !valid_o || ready_i. Load on free; when ready_i && !load, valid_o clears. data_o and the flags only change on load.
- ready_o = (state==STREAM) && output register free. This is combinational from ready_i; there is no combinational path from valid_i.
- Upstream-to-downstream latency is 1 cycle: a pixel accepted at edge N appears on valid_o after edge N.
- FSM:
  - IDLE: on start_i go to STREAM, clearing counters. start_i while busy is ignored.
  - STREAM: on each upstream handshake (valid_i && ready_o), load the pixel. sof_o=(row==0 && col==0); eol_o=(col==DEPTH_P-1). col wraps at DEPTH_P-1, and row increments on wrap. On the handshake of the pixel at (HEIGHT_P-1, DEPTH_P-1), go to FLUSH.
  - FLUSH: whenever the register is free, load a pad beat with data_o=PAD_P, pad_o=1, sof_o=0, eol_o=0, and increment padcnt. Stop loading after FLUSH_P beats. When the last pad beat completes its downstream handshake, go to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- Counters are sized by $clog2 of DEPTH_P, HEIGHT_P, and FLUSH_P+1.
- Backpressure: while ready_i=0 with valid_o=1, data_o and the flags hold stable, and ready_o=0.
- Upstream valid_i in IDLE, FLUSH, or DONE is not accepted (ready_o=0).
- Reset mid-frame aborts immediately: outputs return to reset values and no done_o pulse is issued.

Optional Feature:
CONV2D_SRC_REPLICATE_EN.
- Defined: pad beats carry the last real pixel of the frame, latched on its upstream handshake, instead of PAD_P. pad_o is still asserted.
- Undefined: pad beats carry PAD_P and the latch is not built.

Decomposition:
- conv2d_pkg holds:
  - the state enum typedef src_state_e {IDLE, STREAM, FLUSH, DONE};
  - localparam default geometry (WIDTH 8, DEPTH 16, HEIGHT 16);
  - a helper function for the flush default.
- One sub-module, raster_counter: col/row counters with enable, clear, and wrap, plus sof/eol/last-pixel flags. It is reused later by the output-side frame sink.

Test Plan:
1. DEPTH_P=4, HEIGHT_P=3, FLUSH_P=6, ready_i=1. Pulse start, feed pixels 1..12 back-to-back. Required: valid_o carries 1..12 then six 0s; sof_o only on pixel 1; eol_o on 4, 8, 12; pad_o on the last 6 beats; done_o pulses once, one cycle after the final pad handshake; 18 beats total.
2. Same frame with ready_i toggling 1,0,0,1 repeating. Required: data_o is stable while stalled, and the downstream sequence is identical to test 1 with no loss or duplication.
3. Upstream valid_i gaps (every other cycle). Required: output is correct, with valid_o gapped accordingly and latency 1.
4. Assert rst_i after pixel 7 is accepted, then start a new frame. Required: outputs drop to 0 asynchronously, no done_o is issued, and the next frame's first beat has sof_o=1.
5. start_i pulsed mid-frame and valid_i held high in IDLE. Required: the restart is ignored, ready_o=0 in IDLE, and no beats are emitted.
6. With CONV2D_SRC_REPLICATE_EN defined and the last pixel 0xA5: all pad beats carry 0xA5 with pad_o=1.
